// File: rtl/frs_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package frs_pkg;

    localparam int FRS_DEPTH = 3;
    localparam int FRS_CW    = 2;

    typedef logic [FRS_CW-1:0] frs_credit_t;

    function automatic frs_credit_t frs_wrap_inc(frs_credit_t idx);
        return (idx == frs_credit_t'(FRS_DEPTH - 1)) ? '0 : idx + frs_credit_t'(1);
    endfunction

endpackage

// File: rtl/frs_skidq.sv
// Three-entry register queue holding words returned by the FIFO.
module frs_skidq
    import frs_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          clear,
    output logic [DW-1:0] head_data,
    output frs_credit_t   level
);

    logic [DW-1:0] mem_q [FRS_DEPTH];
    frs_credit_t   hd_q, hd_d;
    frs_credit_t   tl_q, tl_d;
    frs_credit_t   lvl_q, lvl_d;

    always_comb begin
        hd_d  = hd_q;
        tl_d  = tl_q;
        lvl_d = lvl_q;
        if (clear) begin
            hd_d  = '0;
            tl_d  = '0;
            lvl_d = '0;
        end else begin
            if (push) tl_d = frs_wrap_inc(tl_q);
            if (pop)  hd_d = frs_wrap_inc(hd_q);
            case ({push, pop})
                2'b10:   lvl_d = lvl_q + frs_credit_t'(1);
                2'b01:   lvl_d = lvl_q - frs_credit_t'(1);
                default: lvl_d = lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            hd_q  <= '0;
            tl_q  <= '0;
            lvl_q <= '0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            lvl_q <= lvl_d;
            if (push && !clear) mem_q[tl_q] <= push_data;
        end
    end

    assign head_data = mem_q[hd_q];
    assign level     = lvl_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a one-cycle-latency FIFO read port into a valid/ready stream,
// issuing reads against credits so out_ready never reaches fifo_rd_en.
module fifo_rd_stream
    import frs_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          rd_clk,
    input  logic          rd_rst,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rd_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    level
);

    frs_credit_t credit_q, credit_d;
    frs_credit_t lvl;
    logic        inflight_q;
    logic        push, pop;

    // Reset also gates the strobe so no FIFO word is popped into a held-reset pipe.
    assign fifo_rd_en = !rd_rst && !fifo_empty && !flush
                        && (credit_q < frs_credit_t'(FRS_DEPTH));

    assign out_valid = (lvl != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign push      = inflight_q && !flush;

    always_comb begin
        credit_d = credit_q;
        if (flush) begin
            credit_d = '0;
        end else begin
            case ({fifo_rd_en, pop})
                2'b10:   credit_d = credit_q + frs_credit_t'(1);
                2'b01:   credit_d = credit_q - frs_credit_t'(1);
                default: credit_d = credit_q;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            credit_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            inflight_q <= fifo_rd_en;
        end
    end

    frs_skidq #(.DW(DW)) u_q (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .clear     (flush),
        .head_data (out_data),
        .level     (lvl)
    );

    assign level = lvl;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: FIFO model drives the read port, monitor checks the stream.
module tb_fifo_rd_stream;

    localparam int DW = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    level;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;

    // src_q: words still in the FIFO; exp_q: words read out but not yet delivered
    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_q [$];
    bit            gap;
    bit            issued_prev;
    bit            en_obs;
    bit            v_obs;
    int            cyc;

    logic          mon_v, mon_r, mon_f;
    logic [DW-1:0] mon_d;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(.DW(DW)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle: drive FIFO flag, check model-derived outputs, advance the model.
    task automatic step();
        bit            en_exp;
        int            lvl_exp;
        logic [DW-1:0] w;
        w = '0;
        @(negedge rd_clk);
        fifo_empty = (src_q.size() == 0) || gap;
        #1;
        en_exp  = !rd_rst && !fifo_empty && !flush && (exp_q.size() < 3);
        lvl_exp = exp_q.size() - int'(issued_prev);
        chk("rd_en", fifo_rd_en, en_exp);
        chk("level", level, lvl_exp);
        chk("out_valid", out_valid, lvl_exp != 0);
        if (lvl_exp > 0) chk("head", out_data, exp_q[0]);
        en_obs = fifo_rd_en;
        v_obs  = out_valid;
        @(posedge rd_clk);
        cyc++;
        if (rd_rst || flush) exp_q.delete();
        if (en_exp) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
        end
        issued_prev = en_exp;
        assert (exp_q.size() <= 3);
        #1;
        fifo_rd_data = en_exp ? w : DW'($urandom);
    endtask

    initial begin : monitor
        forever begin
            @(negedge rd_clk);
            #2;
            mon_v = out_valid;
            mon_r = out_ready;
            mon_f = flush;
            mon_d = out_data;
            @(posedge rd_clk);
            if (mon_v && mon_r && !mon_f && !rd_rst) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_out: got %0h expected no transfer", mon_d);
                end else begin
                    chk("out_data", mon_d, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drain(input int budget);
        int k;
        k = 0;
        out_ready = 1'b1;
        gap = 1'b0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        chk("drain_done", exp_q.size() + src_q.size(), 0);
    endtask

    initial begin : main
        int en_cnt, first_en, last_en, v_cnt, first_v, last_v, base, k, remain;
        logic [DW-1:0] nxt;

        rd_rst = 1'b1; fifo_empty = 1'b1; flush = 1'b0; out_ready = 1'b0;
        fifo_rd_data = '0; gap = 1'b0; issued_prev = 1'b0; cyc = 0;
        #2;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", level, 0);
        repeat (2) step();
        rd_rst = 1'b0;

        // idle with empty FIFO
        repeat (20) begin
            step();
            chk("idle_data", out_data, 0);
        end

        // back-to-back streaming
        for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
        out_ready = 1'b1;
        base = n_out;
        en_cnt = 0; v_cnt = 0; first_en = -1; first_v = -1; last_en = 0; last_v = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (en_obs) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
                last_en = i;
            end
            if (v_obs) begin
                v_cnt++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        chk("stream_en_cnt", en_cnt, 8);
        chk("stream_en_run", last_en - first_en, 7);
        chk("stream_latency", first_v - first_en, 2);
        chk("stream_v_run", last_v - first_v, 7);
        chk("stream_words", n_out - base, 8);

        // backpressure
        for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
        out_ready = 1'b0;
        base = n_out;
        en_cnt = 0;
        repeat (10) begin
            step();
            if (en_obs) en_cnt++;
        end
        chk("bp_reads", en_cnt, 3);
        chk("bp_level", level, 3);
        chk("bp_data", out_data, 16'h0001);
        drain(50);
        chk("bp_words", n_out - base, 8);

        // random traffic
        for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom));
        base = n_out;
        k = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && k < 20000) begin
            gap = ($urandom_range(3) == 0);
            out_ready = 1'($urandom_range(1));
            step();
            k++;
        end
        chk("rand_done", exp_q.size() + src_q.size(), 0);
        chk("rand_words", n_out - base, 1000);
        gap = 1'b0;

        // flush with two buffered words and one in flight
        for (int i = 0; i < 10; i++) src_q.push_back(DW'(16'h0100 + i));
        out_ready = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (!(level == 2 && exp_q.size() == 3) && k < 10);
        chk("flush_setup", level, 2);
        nxt = src_q[0];
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_level", level, 0);
        k = 0;
        while (!out_valid && k < 10) begin
            step();
            k++;
        end
        chk("flush_next", out_data, nxt);
        drain(50);

        // asynchronous reset mid-stream
        for (int i = 0; i < 20; i++) src_q.push_back(DW'(16'h0A00 + i));
        out_ready = 1'b1;
        repeat (6) step();
        @(negedge rd_clk);
        fifo_empty = (src_q.size() == 0);
        #3;
        rd_rst = 1'b1;
        #1;
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_data", out_data, 0);
        @(posedge rd_clk);
        cyc++;
        exp_q.delete();
        issued_prev = 1'b0;
        #1;
        fifo_rd_data = DW'($urandom);
        step();
        rd_rst = 1'b0;
        remain = src_q.size();
        base = n_out;
        drain(100);
        chk("arst_resume", n_out - base, remain);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
